uart_frame_rx: RTL and testbench

- Serial receive stage feeding the configuration decoder.
- Deserialises an asynchronous 8N1 stream (optional parity) on `rx` into 8-bit frames.
- Presents each frame on `frame` with a one-clock `frame_valid` strobe.
- `frame` stays held after the strobe, so the downstream stage can latch it in a later cycle.

---
 rtl/uart_frame_rx.sv | 138 +++++++++++++
 tb/tb_uart_frame_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// 8-bit asynchronous serial receiver with optional parity check.
// Emits each good byte with a one-clock strobe; stop or parity failures give a one-clock error strobe.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] frame,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Detect clock counts as the first of the HALF clocks before the start sample.
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  // state    | meaning
  // S_IDLE   | line idle, waiting for start edge (or for line high after a break)
  // S_START  | timing to mid start bit to reject glitches
  // S_DATA   | sampling 8 data bits LSB first
  // S_PARITY | sampling the parity bit
  // S_STOP   | sampling the stop bit, then one clock to report the result
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bitn;
  logic [7:0]      r_shift;
  logic            r_par_bad;
  logic            r_stop_seen;
  logic            r_stop_ok;
  logic            r_rearm;
  logic [7:0]      r_frame;
  logic            r_frame_valid;
  logic            r_frame_err;
  logic            w_bit_tc;
  logic            w_half_tc;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_tc    = (r_cnt == BIT_TC);
    w_half_tc   = (r_cnt == HALF_TC);
    case (r_state)
      S_IDLE:   if (r_rearm && !r_rx_s) w_state_nxt = S_START;
      S_START:  if (w_half_tc) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_bit_tc && (r_bitn == 3'd7)) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_tc) w_state_nxt = S_STOP;
      S_STOP:   if (r_stop_seen) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_sync1       <= 1'b1;
      r_rx_s        <= 1'b1;
      r_cnt         <= '0;
      r_bitn        <= '0;
      r_shift       <= '0;
      r_par_bad     <= 1'b0;
      r_stop_seen   <= 1'b0;
      r_stop_ok     <= 1'b0;
      r_rearm       <= 1'b1;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_sync1       <= rx;
      r_rx_s        <= r_sync1;
      r_state       <= w_state_nxt;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt       <= '0;
          r_bitn      <= '0;
          r_par_bad   <= 1'b0;
          r_stop_seen <= 1'b0;
          if (!r_rearm && r_rx_s) r_rearm <= 1'b1;
        end
        S_START: r_cnt <= w_half_tc ? '0 : r_cnt + CW'(1);
        S_DATA: begin
          if (w_bit_tc) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bitn  <= r_bitn + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_tc) begin
            r_cnt     <= '0;
            r_par_bad <= (((^r_shift) ^ r_rx_s) != PARITY_ODD);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (!r_stop_seen) begin
            if (w_bit_tc) begin
              r_stop_seen <= 1'b1;
              r_stop_ok   <= r_rx_s;
              // A low stop bit means a break may follow; wait for idle before rearming.
              if (!r_rx_s) r_rearm <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_stop_seen <= 1'b0;
            if (r_stop_ok && !r_par_bad) begin
              r_frame       <= r_shift;
              r_frame_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: an 8N1 instance and an even-parity instance sharing clock and reset.
// Expected events go into per-instance queues when a frame is sent and are matched when the DUT strobes.
module tb_uart_frame_rx;

  localparam int CPB = 16;

  typedef struct packed {
    logic       is_valid;
    logic [7:0] data;
  } sb_t;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       ok;
  } vec8_t;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       ok;
  } vecp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic [7:0] frame0, frame1;
  logic       fv0, fe0, busy0;
  logic       fv1, fe1, busy1;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   drv_cyc = 0;
  int   last_start_cyc = 0;
  int   last_valid_cyc = 0;
  sb_t  q0[$];
  sb_t  q1[$];
  logic [7:0] hold0 = 8'h00;
  logic [7:0] hold1 = 8'h00;
  logic pv0 = 0, pe0 = 0, pv1 = 0, pe1 = 0;

  vec8_t tbl8[5];
  vecp_t tblp[6];

  uart_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx0), .frame(frame0),
    .frame_valid(fv0), .frame_err(fe0), .busy(busy0)
  );

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst(rst), .rx(rx1), .frame(frame1),
    .frame_valid(fv1), .frame_err(fe1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sb_event(input int which, input logic v, input logic e, input logic [7:0] f,
                          input logic pv, input logic pe);
    sb_t x;
    if (v || e) begin
      check($sformatf("dut%0d_not_both", which), {31'd0, v && e}, 0);
      check($sformatf("dut%0d_one_clock", which), {31'd0, (v && pv) || (e && pe)}, 0);
      if ((which == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL dut%0d_unexpected_event valid=%0b err=%0b frame=%02h expected no event",
                 which, v, e, f);
      end else begin
        x = (which == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_event_kind", which), {31'd0, v}, {31'd0, x.is_valid});
        if (x.is_valid) begin
          check($sformatf("dut%0d_frame", which), {24'd0, f}, {24'd0, x.data});
          if (which == 0) hold0 = x.data; else hold1 = x.data;
        end else begin
          check($sformatf("dut%0d_frame_held", which), {24'd0, f},
                {24'd0, (which == 0) ? hold0 : hold1});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold0 = 8'h00;
      hold1 = 8'h00;
    end else begin
      if (fv0) last_valid_cyc = cyc;
      sb_event(0, fv0, fe0, frame0, pv0, pe0);
      sb_event(1, fv1, fe1, frame1, pv1, pe1);
    end
    pv0 = fv0; pe0 = fe0; pv1 = fv1; pe1 = fe1;
  end

  task automatic drive(input int which, input logic v, input int nclk);
    @(posedge clk);
    #1;
    if (which == 0) rx0 = v; else rx1 = v;
    drv_cyc = cyc;
    repeat (nclk - 1) @(posedge clk);
  endtask

  task automatic send(input int which, input logic [7:0] d, input int par, input logic stop,
                      input int gap);
    drive(which, 1'b0, CPB);
    last_start_cyc = drv_cyc;
    for (int i = 0; i < 8; i++) drive(which, d[i], CPB);
    if (par >= 0) drive(which, par[0], CPB);
    drive(which, stop, CPB);
    if (gap > 0) drive(which, 1'b1, gap * CPB);
  endtask

  task automatic expect_ev(input int which, input logic is_valid, input logic [7:0] d);
    sb_t x;
    x.is_valid = is_valid;
    x.data     = d;
    if (which == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < n) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending_events", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    tbl8[0] = '{data: 8'hA5, stop: 1'b1, ok: 1'b1};
    tbl8[1] = '{data: 8'h00, stop: 1'b1, ok: 1'b1};
    tbl8[2] = '{data: 8'hFF, stop: 1'b1, ok: 1'b1};
    tbl8[3] = '{data: 8'h80, stop: 1'b0, ok: 1'b0};
    tbl8[4] = '{data: 8'h01, stop: 1'b1, ok: 1'b1};
    tblp[0] = '{data: 8'h07, par: 1'b1, ok: 1'b1};
    tblp[1] = '{data: 8'h07, par: 1'b0, ok: 1'b0};
    tblp[2] = '{data: 8'h00, par: 1'b0, ok: 1'b1};
    tblp[3] = '{data: 8'h80, par: 1'b1, ok: 1'b1};
    tblp[4] = '{data: 8'hFF, par: 1'b1, ok: 1'b0};
    tblp[5] = '{data: 8'hFE, par: 1'b1, ok: 1'b1};

    rst = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;

    // reset held with the line toggling
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      rx0 = ~rx0;
      rx1 = ~rx1;
      @(negedge clk);
      check("reset_outputs_dut0", {21'd0, frame0, fv0, fe0, busy0}, 0);
      check("reset_outputs_dut1", {21'd0, frame1, fv1, fe1, busy1}, 0);
    end
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_after_reset_dut0", {21'd0, frame0, fv0, fe0, busy0}, 0);
    check("idle_after_reset_dut1", {21'd0, frame1, fv1, fe1, busy1}, 0);

    // single byte with latency from the raw falling edge
    expect_ev(0, 1'b1, 8'h3A);
    send(0, 8'h3A, -1, 1'b1, 2);
    wait_drain(400);
    check("latency_raw_edge_to_valid", last_valid_cyc - last_start_cyc, 155);
    repeat (50) @(negedge clk);
    check("frame_held_50_clocks", {24'd0, frame0}, 32'h3A);

    // back-to-back frames then a short glitch
    expect_ev(0, 1'b1, 8'h3A);
    expect_ev(0, 1'b1, 8'hC5);
    send(0, 8'h3A, -1, 1'b1, 0);
    send(0, 8'hC5, -1, 1'b1, 1);
    wait_drain(400);
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 1);
    repeat (3) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy0}, 1);
    repeat (7) @(negedge clk);
    check("glitch_busy_low_after_half", {31'd0, busy0}, 0);
    repeat (40) @(negedge clk);
    check("glitch_frame_unchanged", {24'd0, frame0}, 32'hC5);

    // stop-bit failure followed by a long break, then a good byte
    expect_ev(0, 1'b0, 8'h00);
    send(0, 8'h55, -1, 1'b0, 0);
    drive(0, 1'b0, 40 * CPB);
    check("break_no_extra_event", q0.size(), 0);
    check("break_frame_held", {24'd0, frame0}, 32'hC5);
    drive(0, 1'b1, 2 * CPB);
    expect_ev(0, 1'b1, 8'h12);
    send(0, 8'h12, -1, 1'b1, 2);
    wait_drain(400);

    // table: plain 8N1 vectors
    for (int i = 0; i < 5; i++) begin
      expect_ev(0, tbl8[i].ok, tbl8[i].data);
      send(0, tbl8[i].data, -1, tbl8[i].stop, 2);
      wait_drain(400);
    end

    // table: even-parity vectors
    for (int i = 0; i < 6; i++) begin
      expect_ev(1, tblp[i].ok, tblp[i].data);
      send(1, tblp[i].data, int'(tblp[i].par), 1'b1, 2);
      wait_drain(400);
    end
    check("parity_dut_last_good_frame", {24'd0, frame1}, 32'hFE);

    // reset in the middle of a frame
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 4 * CPB);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", {21'd0, frame0, fv0, fe0, busy0}, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b1, 2 * CPB);
    check("midframe_no_pulse", q0.size(), 0);
    check("midframe_idle", {21'd0, frame0, fv0, fe0, busy0}, 0);
    expect_ev(0, 1'b1, 8'h81);
    send(0, 8'h81, -1, 1'b1, 2);
    wait_drain(400);
    check("after_reset_frame", {24'd0, frame0}, 32'h81);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
